// File: rtl/systolic_array_pkg.sv
// Shared definitions for the systolic matrix-multiply slice.
// Contents: address/dimension widths and the controller state enum.
package systolic_array_pkg;
  localparam int ADDR_W = 16;
  localparam int DIM_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACC,
    ST_WRITE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/systolic_array_if.sv
// Memory-side bus bundle of the systolic array: two read ports (a, b)
// and one write port (c), each with a req/ack handshake.
//   master : the array controller (drives req/addr/wdata, receives ack/rdata)
//   slave  : the memory model or interconnect
interface systolic_array_if
  import systolic_array_pkg::*;
#(
  parameter int BW = 256
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_ack;
  logic [BW-1:0]     a_rdata;

  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic              b_ack;
  logic [BW-1:0]     b_rdata;

  logic              c_req;
  logic [ADDR_W-1:0] c_addr;
  logic [BW-1:0]     c_wdata;
  logic              c_ack;

  modport master (
    output a_req, a_addr, input a_ack, a_rdata,
    output b_req, b_addr, input b_ack, b_rdata,
    output c_req, c_addr, c_wdata, input c_ack
  );

  modport slave (
    input a_req, a_addr, output a_ack, a_rdata,
    input b_req, b_addr, output b_ack, b_rdata,
    input c_req, c_addr, c_wdata, output c_ack
  );
endinterface

// File: rtl/systolic_pe.sv
// Single multiply-accumulate cell. Unsigned, wraps modulo 2^DATA_WIDTH.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : zero the accumulator (wins over en_i)
//   en_i       : add a_i*b_i to the accumulator this cycle
//   a_i, b_i   : operands
//   acc_o      : current accumulator value
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] acc_o
);
  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + a_i * b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array_top.sv
// Tiled output-stationary matrix multiplier C = A x B.
// For every ARRAY_HEIGHT x ARRAY_WIDTH output tile it streams one A^T word
// and one B word per k, accumulates the outer product in the PE grid, then
// writes the tile back one row per bus word.
//   clk, reset                      : clock, synchronous active-high reset
//   start_i                         : start pulse (ignored unless idle)
//   m, n, p                         : matrix dimensions, latched at start
//   base_addr_a/b/c                 : word base addresses, latched at start
//   operation_done                  : one-cycle completion pulse
//   bus                             : a/b read ports and c write port
// Optional build macro SYSTOLIC_PERF_CNT_EN adds busy_cycles, a_reqs,
// b_reqs and c_reqs activity counters (cleared on start).
module systolic_array_top
  import systolic_array_pkg::*;
#(
  parameter int ARRAY_WIDTH      = 16,
  parameter int ARRAY_HEIGHT     = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int BUS_WIDTH_BYTES  = 32,
  parameter int DATA_WIDTH_BYTES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  n,
  input  logic [DIM_W-1:0]  p,
  input  logic [ADDR_W-1:0] base_addr_a,
  input  logic [ADDR_W-1:0] base_addr_b,
  input  logic [ADDR_W-1:0] base_addr_c,
  output logic              operation_done,
  systolic_array_if.master  bus
`ifdef SYSTOLIC_PERF_CNT_EN
  ,
  output logic [31:0]       busy_cycles,
  output logic [31:0]       a_reqs,
  output logic [31:0]       b_reqs,
  output logic [31:0]       c_reqs
`endif
);
  localparam int ELEMS = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
  localparam int RW    = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
  localparam int AWD   = ARRAY_HEIGHT * DATA_WIDTH;
  localparam int BWD   = ARRAY_WIDTH * DATA_WIDTH;

  if (ARRAY_WIDTH > ELEMS || ARRAY_HEIGHT > ELEMS) begin : g_bad_cfg
    $error("array dimension exceeds elements per bus word");
  end

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   n_q, n_d, m_tiles_q, m_tiles_d, p_tiles_q, p_tiles_d;
  logic [DIM_W-1:0]   k_q, k_d, ti_q, ti_d, tj_q, tj_d;
  logic [ADDR_W-1:0]  base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic               zero_q, zero_d;
  logic               a_done_q, a_done_d, b_done_q, b_done_d;
  logic [RW-1:0]      r_q, r_d;
  logic [AWD-1:0]     a_word_q, a_word_d;
  logic [BWD-1:0]     b_word_q, b_word_d;
  logic               a_fire, b_fire, c_fire, pe_clr, pe_en;
  logic [DATA_WIDTH-1:0] acc_w [ARRAY_HEIGHT][ARRAY_WIDTH];
  logic [BWD-1:0]     row_w;
  logic               unused_rdata;

  // Only the low lanes of each read word feed the grid.
  assign unused_rdata = ^{bus.a_rdata, bus.b_rdata};

  assign a_fire = bus.a_req & bus.a_ack;
  assign b_fire = bus.b_req & bus.b_ack;
  assign c_fire = bus.c_req & bus.c_ack;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_tiles_d = m_tiles_q;
    p_tiles_d = p_tiles_q;
    k_d       = k_q;
    ti_d      = ti_q;
    tj_d      = tj_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    base_c_d  = base_c_q;
    zero_d    = zero_q;
    a_done_d  = a_done_q;
    b_done_d  = b_done_q;
    r_d       = r_q;
    a_word_d  = a_word_q;
    b_word_d  = b_word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_d       = n;
          m_tiles_d = m / DIM_W'(ARRAY_HEIGHT);
          p_tiles_d = p / DIM_W'(ARRAY_WIDTH);
          base_a_d  = base_addr_a;
          base_b_d  = base_addr_b;
          base_c_d  = base_addr_c;
          zero_d    = (m == '0) || (n == '0) || (p == '0);
          k_d       = '0;
          ti_d      = '0;
          tj_d      = '0;
          a_done_d  = 1'b0;
          b_done_d  = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (zero_q) begin
          state_d = ST_DONE;
        end else begin
          if (a_fire) begin
            a_done_d = 1'b1;
            a_word_d = bus.a_rdata[AWD-1:0];
          end
          if (b_fire) begin
            b_done_d = 1'b1;
            b_word_d = bus.b_rdata[BWD-1:0];
          end
          if ((a_done_q || a_fire) && (b_done_q || b_fire)) begin
            state_d = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        if (k_q == n_q - 16'd1) begin
          r_d     = '0;
          state_d = ST_WRITE;
        end else begin
          k_d     = k_q + 16'd1;
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (c_fire) begin
          if (r_q == RW'(ARRAY_HEIGHT - 1)) begin
            k_d = '0;
            if (tj_q + 16'd1 < p_tiles_q) begin
              tj_d    = tj_q + 16'd1;
              state_d = ST_LOAD;
            end else if (ti_q + 16'd1 < m_tiles_q) begin
              ti_d    = ti_q + 16'd1;
              tj_d    = '0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      m_tiles_q <= '0;
      p_tiles_q <= '0;
      k_q       <= '0;
      ti_q      <= '0;
      tj_q      <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      base_c_q  <= '0;
      zero_q    <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      r_q       <= '0;
      a_word_q  <= '0;
      b_word_q  <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_tiles_q <= m_tiles_d;
      p_tiles_q <= p_tiles_d;
      k_q       <= k_d;
      ti_q      <= ti_d;
      tj_q      <= tj_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      base_c_q  <= base_c_d;
      zero_q    <= zero_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      r_q       <= r_d;
      a_word_q  <= a_word_d;
      b_word_q  <= b_word_d;
    end
  end

  // Accumulators are idle during the first LOAD of a tile, so clearing
  // there gives every tile a fresh start without an extra state.
  assign pe_clr = (state_q == ST_LOAD) && (k_q == '0);
  assign pe_en  = (state_q == ST_ACC);

  for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_col
      systolic_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr_i (pe_clr),
        .en_i  (pe_en),
        .a_i   (a_word_q[r*DATA_WIDTH +: DATA_WIDTH]),
        .b_i   (b_word_q[c*DATA_WIDTH +: DATA_WIDTH]),
        .acc_o (acc_w[r][c])
      );
    end
  end

  always_comb begin
    row_w = '0;
    for (int c = 0; c < ARRAY_WIDTH; c++) begin
      row_w[c*DATA_WIDTH +: DATA_WIDTH] = acc_w[r_q][c];
    end
  end

  // Address and write data are forced to zero whenever no request is up.
  always_comb begin
    bus.a_req   = (state_q == ST_LOAD) && !zero_q && !a_done_q;
    bus.b_req   = (state_q == ST_LOAD) && !zero_q && !b_done_q;
    bus.c_req   = (state_q == ST_WRITE);
    bus.a_addr  = '0;
    bus.b_addr  = '0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    if (bus.a_req) bus.a_addr = base_a_q + k_q * m_tiles_q + ti_q;
    if (bus.b_req) bus.b_addr = base_b_q + k_q * p_tiles_q + tj_q;
    if (bus.c_req) begin
      bus.c_addr = base_c_q
                 + (ti_q * DIM_W'(ARRAY_HEIGHT) + DIM_W'(r_q)) * p_tiles_q + tj_q;
      bus.c_wdata[BWD-1:0] = row_w;
    end
  end

  assign operation_done = (state_q == ST_DONE);

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] busy_q, a_cnt_q, b_cnt_q, c_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      busy_q  <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      if (state_q != ST_IDLE) busy_q <= busy_q + 32'd1;
      if (a_fire) a_cnt_q <= a_cnt_q + 32'd1;
      if (b_fire) b_cnt_q <= b_cnt_q + 32'd1;
      if (c_fire) c_cnt_q <= c_cnt_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
  assign a_reqs      = a_cnt_q;
  assign b_reqs      = b_cnt_q;
  assign c_reqs      = c_cnt_q;
`endif
endmodule

// File: tb/tb_systolic_array_top.sv
module tb_systolic_array_top;
  localparam int AW = 2;
  localparam int AH = 2;
  localparam int BW = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] m = '0, n = '0, p = '0;
  logic [15:0] base_a = '0, base_b = '0, base_c = '0;
  logic        operation_done;
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] busy_cycles, a_reqs, b_reqs, c_reqs;
`endif

  systolic_array_if #(.BW(BW)) bus ();

  systolic_array_top #(
    .ARRAY_WIDTH(AW), .ARRAY_HEIGHT(AH), .DATA_WIDTH(8),
    .BUS_WIDTH_BYTES(4), .DATA_WIDTH_BYTES(1)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .m(m), .n(n), .p(p),
    .base_addr_a(base_a), .base_addr_b(base_b), .base_addr_c(base_c),
    .operation_done(operation_done),
    .bus(bus)
`ifdef SYSTOLIC_PERF_CNT_EN
    , .busy_cycles(busy_cycles), .a_reqs(a_reqs), .b_reqs(b_reqs), .c_reqs(c_reqs)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int A_m [8][8];
  int B_m [8][8];
  int cyc = 0, a_cnt = 0, b_cnt = 0, c_cnt = 0, req_seen = 0, last_c_cyc = 0;
  logic [15:0] wr_addr[$], exp_addr[$];
  logic [31:0] wr_data[$], exp_data[$];
  int n_checks = 0, n_fail = 0;
  int done_pulses, timed_out, done_gap;

  // Memory responder: ack is randomly raised/dropped while req is up; a
  // transfer is logged when ack is raised, since it completes on the next edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.a_req || bus.b_req || bus.c_req) req_seen++;
    bus.a_ack   = bus.a_req && ($urandom_range(0, 1) == 1);
    bus.b_ack   = bus.b_req && ($urandom_range(0, 1) == 1);
    bus.c_ack   = bus.c_req && ($urandom_range(0, 1) == 1);
    bus.a_rdata = mem[bus.a_addr[7:0]];
    bus.b_rdata = mem[bus.b_addr[7:0]];
    if (bus.a_ack) a_cnt++;
    if (bus.b_ack) b_cnt++;
    if (bus.c_ack) begin
      c_cnt++;
      wr_addr.push_back(bus.c_addr);
      wr_data.push_back(bus.c_wdata);
      last_c_cyc = cyc;
    end
  end

  // Places A^T and B into memory in the bus layout.
  task automatic load_mem(input int mm, nn, pp, ba, bb);
    logic [31:0] w;
    for (int k = 0; k < nn; k++) begin
      for (int ti = 0; ti < mm / AH; ti++) begin
        w = '0;
        for (int r = 0; r < AH; r++) w |= 32'(A_m[ti*AH+r][k] & 255) << (r * 8);
        mem[8'(ba + k * (mm / AH) + ti)] = w;
      end
      for (int tj = 0; tj < pp / AW; tj++) begin
        w = '0;
        for (int c = 0; c < AW; c++) w |= 32'(B_m[k][tj*AW+c] & 255) << (c * 8);
        mem[8'(bb + k * (pp / AW) + tj)] = w;
      end
    end
  endtask

  // Reference: plain matrix product mod 256, emitted in tile/row write order.
  task automatic build_expected(input int mm, nn, pp, bc);
    int sum, row;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    for (int ti = 0; ti < mm / AH; ti++)
      for (int tj = 0; tj < pp / AW; tj++)
        for (int r = 0; r < AH; r++) begin
          row = ti * AH + r;
          w = '0;
          for (int c = 0; c < AW; c++) begin
            sum = 0;
            for (int k = 0; k < nn; k++) sum += A_m[row][tj*AW+c] * 0 + A_m[row][k] * B_m[k][tj*AW+c];
            w |= 32'(sum % 256) << (c * 8);
          end
          exp_addr.push_back(16'(bc + row * (pp / AW) + tj));
          exp_data.push_back(w);
        end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        A_m[i][j] = 0;
        B_m[i][j] = 0;
      end
  endtask

  task automatic set_example();
    clear_mats();
    A_m[0][0] = 1; A_m[0][1] = 2; A_m[1][0] = 3; A_m[1][1] = 4;
    B_m[0][0] = 5; B_m[0][1] = 6; B_m[1][0] = 7; B_m[1][1] = 8;
  endtask

  // Starts one operation and waits (bounded) for operation_done. A second
  // start pulse is injected pulse_at cycles in when pulse_at >= 0.
  task automatic run_op(input int mm, nn, pp, ba, bb, bc, input int pulse_at);
    wr_addr.delete();
    wr_data.delete();
    a_cnt = 0; b_cnt = 0; c_cnt = 0; req_seen = 0;
    done_pulses = 0; timed_out = 1; done_gap = -1;
    @(negedge clk);
    m = 16'(mm); n = 16'(nn); p = 16'(pp);
    base_a = 16'(ba); base_b = 16'(bb); base_c = 16'(bc);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      start_i = (i == pulse_at);
      if (i == pulse_at) begin
        m = 16'd0; n = 16'd9; p = 16'd0;
      end
      if (operation_done) begin
        done_pulses++;
        done_gap = cyc - last_c_cyc;
        timed_out = 0;
        start_i = 1'b0;
        @(negedge clk);
        if (operation_done) done_pulses++;
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.a_req, bus.b_req, bus.c_req, operation_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got req/done %b, expected 0000",
               {bus.a_req, bus.b_req, bus.c_req, operation_done});
    end
    n_checks++;
    if ({bus.a_addr, bus.b_addr, bus.c_addr} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h %h %h, expected 0", bus.a_addr, bus.b_addr, bus.c_addr);
    end
    n_checks++;
    if (bus.c_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h, expected 0", bus.c_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_example();
    set_example();
    load_mem(2, 2, 2, 'h20, 'h30);
    run_op(2, 2, 2, 'h20, 'h30, 0, -1);
    n_checks++;
    if (timed_out !== 0 || done_pulses !== 1) begin
      n_fail++;
      $display("FAIL ex_done: got timeout %0d pulses %0d, expected 0 and 1", timed_out, done_pulses);
    end
    n_checks++;
    if (done_gap !== 1) begin
      n_fail++;
      $display("FAIL ex_done_gap: got %0d cycles after last c, expected 1", done_gap);
    end
    n_checks++;
    if (wr_data.size() !== 2 || wr_addr[0] !== 16'd0 || wr_data[0] !== 32'h0000_1613) begin
      n_fail++;
      $display("FAIL ex_row0: got n=%0d addr %h data %h, expected 2 writes, 0000 00001613",
               wr_data.size(), wr_addr[0], wr_data[0]);
    end
    n_checks++;
    if (wr_data.size() !== 2 || wr_addr[1] !== 16'd1 || wr_data[1] !== 32'h0000_322b) begin
      n_fail++;
      $display("FAIL ex_row1: got addr %h data %h, expected 0001 0000322b", wr_addr[1], wr_data[1]);
    end
    n_checks++;
    if (a_cnt !== 2 || b_cnt !== 2) begin
      n_fail++;
      $display("FAIL ex_reads: got a %0d b %0d, expected 2 and 2", a_cnt, b_cnt);
    end
  endtask

  task automatic test_identity();
    clear_mats();
    for (int i = 0; i < 4; i++) begin
      A_m[i][i] = 1;
      B_m[i][i] = 1;
    end
    load_mem(4, 4, 4, 'h10, 'h40);
    build_expected(4, 4, 4, 'h80);
    run_op(4, 4, 4, 'h10, 'h40, 'h80, -1);
    n_checks++;
    if (timed_out !== 0 || done_pulses !== 1 || a_cnt !== 16 || b_cnt !== 16 || c_cnt !== 8) begin
      n_fail++;
      $display("FAIL id_counts: got to %0d pulses %0d a %0d b %0d c %0d, expected 0 1 16 16 8",
               timed_out, done_pulses, a_cnt, b_cnt, c_cnt);
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      n_checks++;
      if (i >= wr_data.size() || wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        n_fail++;
        $display("FAIL id_write[%0d]: got %h/%h, expected %h/%h",
                 i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_zero_n();
    req_seen = 0;
    @(negedge clk);
    m = 16'd2; n = 16'd0; p = 16'd2;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++;
    if (operation_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_early: got %b one cycle after start, expected 0", operation_done);
    end
    @(negedge clk);
    n_checks++;
    if (operation_done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: got %b two cycles after start, expected 1", operation_done);
    end
    @(negedge clk);
    n_checks++;
    if (operation_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_width: got %b three cycles after start, expected 0", operation_done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_seen !== 0) begin
      n_fail++;
      $display("FAIL zero_noreq: got %0d request cycles, expected 0", req_seen);
    end
  endtask

  task automatic test_overflow();
    clear_mats();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        A_m[i][j] = 16;
        B_m[i][j] = 16;
      end
    load_mem(2, 2, 2, 'h20, 'h30);
    run_op(2, 2, 2, 'h20, 'h30, 'h90, -1);
    n_checks++;
    if (timed_out !== 0 || c_cnt !== 2) begin
      n_fail++;
      $display("FAIL ovf_count: got timeout %0d writes %0d, expected 0 and 2", timed_out, c_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (i >= wr_data.size() || wr_data[i] !== 32'h0 || wr_addr[i] !== 16'(8'h90 + i)) begin
        n_fail++;
        $display("FAIL ovf_write[%0d]: got %h/%h, expected %h/00000000", i, wr_addr[i], wr_data[i], 8'h90 + i);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int seen;
    set_example();
    load_mem(2, 2, 2, 'h20, 'h30);
    @(negedge clk);
    m = 16'd2; n = 16'd2; p = 16'd2;
    base_a = 16'h20; base_b = 16'h30; base_c = 16'h0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.a_req || bus.b_req) seen = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (seen !== 1) begin
      n_fail++;
      $display("FAIL rst_load_seen: got no load request, expected one");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.a_req, bus.b_req, bus.c_req, operation_done} !== 4'b0 || {bus.a_addr, bus.b_addr} !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got req/done %b addr %h %h, expected all 0",
               {bus.a_req, bus.b_req, bus.c_req, operation_done}, bus.a_addr, bus.b_addr);
    end
    reset = 1'b0;
    run_op(2, 2, 2, 'h20, 'h30, 0, -1);
    n_checks++;
    if (timed_out !== 0 || wr_data.size() !== 2 || wr_data[0] !== 32'h1613 || wr_data[1] !== 32'h322b
        || wr_addr[0] !== 16'd0 || wr_addr[1] !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_rerun: got n=%0d %h:%h %h:%h, expected 0000:00001613 0001:0000322b",
               wr_data.size(), wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_busy_start();
    set_example();
    load_mem(2, 2, 2, 'h20, 'h30);
    run_op(2, 2, 2, 'h20, 'h30, 0, 3);
    n_checks++;
    if (timed_out !== 0 || done_pulses !== 1 || a_cnt !== 2 || b_cnt !== 2 || c_cnt !== 2) begin
      n_fail++;
      $display("FAIL busy_counts: got to %0d pulses %0d a %0d b %0d c %0d, expected 0 1 2 2 2",
               timed_out, done_pulses, a_cnt, b_cnt, c_cnt);
    end
    n_checks++;
    if (wr_data.size() !== 2 || wr_data[0] !== 32'h1613 || wr_data[1] !== 32'h322b) begin
      n_fail++;
      $display("FAIL busy_data: got %h %h, expected 00001613 0000322b", wr_data[0], wr_data[1]);
    end
  endtask

  task automatic test_random();
    int mm, nn, pp;
    for (int it = 0; it < 4; it++) begin
      mm = AH * $urandom_range(1, 3);
      pp = AW * $urandom_range(1, 2);
      nn = $urandom_range(1, 4);
      clear_mats();
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          A_m[i][j] = $urandom_range(0, 255);
          B_m[i][j] = $urandom_range(0, 255);
        end
      load_mem(mm, nn, pp, 'h10, 'h40);
      build_expected(mm, nn, pp, 'h80);
      run_op(mm, nn, pp, 'h10, 'h40, 'h80, -1);
      n_checks++;
      if (timed_out !== 0 || done_pulses !== 1 || a_cnt !== (mm / AH) * (pp / AW) * nn
          || b_cnt !== a_cnt || c_cnt !== exp_data.size()) begin
        n_fail++;
        $display("FAIL rand%0d_counts: m%0d n%0d p%0d got to %0d pulses %0d a %0d b %0d c %0d",
                 it, mm, nn, pp, timed_out, done_pulses, a_cnt, b_cnt, c_cnt);
      end
      for (int i = 0; i < exp_data.size(); i++) begin
        n_checks++;
        if (i >= wr_data.size() || wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL rand%0d_write[%0d]: got %h/%h, expected %h/%h",
                   it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    bus.a_ack = 1'b0; bus.b_ack = 1'b0; bus.c_ack = 1'b0;
    bus.a_rdata = '0; bus.b_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_example();
    test_identity();
    test_zero_n();
    test_overflow();
    test_reset_mid_load();
    test_busy_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
